// File: rtl/logic_unit_arbiter_if.sv
// Request/response bus between two requesters and the shared logic unit arbiter.
interface logic_unit_arbiter_if #(
    parameter int unsigned WIDTH = 32
) ();
    // Request channel, bit i / suffix i belongs to requester i
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic             req_op0;
    logic [WIDTH-1:0] req_x0;
    logic [WIDTH-1:0] req_y0;
    logic             req_op1;
    logic [WIDTH-1:0] req_x1;
    logic [WIDTH-1:0] req_y1;

    // Response channel, one shared data bus with per-requester valid/ready
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    // Requester side
    modport master (
        output req_valid, req_op0, req_x0, req_y0, req_op1, req_x1, req_y1,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_op0, req_x0, req_y0, req_op1, req_x1, req_y1,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one AND/OR logic unit between two requesters.
// One operation in flight; result is registered and held until the owning
// requester accepts it. Per-requester completion counters wrap.
module logic_unit_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    logic_unit_arbiter_if.slave  bus,
    output logic                 busy,
    output logic                 last_grant,
    output logic [CNT_W-1:0]     done_cnt0,
    output logic [CNT_W-1:0]     done_cnt1
);

    localparam int unsigned NREQ = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t             state_q,      state_d;
    logic               last_grant_q, last_grant_d;
    logic [WIDTH-1:0]   rsp_data_q,   rsp_data_d;
    logic [NREQ-1:0]    rsp_valid_q,  rsp_valid_d;
    logic               busy_q,       busy_d;
    logic [CNT_W-1:0]   done_cnt0_q,  done_cnt0_d;
    logic [CNT_W-1:0]   done_cnt1_q,  done_cnt1_d;

    logic               grant_c;
    logic [NREQ-1:0]    req_ready_c;
    logic               accept_c;
    logic               rsp_hs_c;
    logic               op_sel_c;
    logic [WIDTH-1:0]   x_sel_c;
    logic [WIDTH-1:0]   y_sel_c;
    logic [WIDTH-1:0]   result_c;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        grant_c = 1'b0;
        unique case (bus.req_valid)
            2'b10:   grant_c = 1'b1;
            2'b11:   grant_c = ~last_grant_q;
            default: grant_c = 1'b0;
        endcase
    end

    // Offer ready only to the granted requester, and only while idle
    always_comb begin
        req_ready_c = '0;
        if ((state_q == IDLE) && (|bus.req_valid)) begin
            req_ready_c[grant_c] = 1'b1;
        end
    end

    assign accept_c = (state_q == IDLE) && (|(bus.req_valid & req_ready_c));
    assign rsp_hs_c = (state_q == RESP) && bus.rsp_ready[last_grant_q];

    // Steer the granted requester's operands into the logic unit
    always_comb begin
        op_sel_c = bus.req_op0;
        x_sel_c  = bus.req_x0;
        y_sel_c  = bus.req_y0;
        if (grant_c) begin
            op_sel_c = bus.req_op1;
            x_sel_c  = bus.req_x1;
            y_sel_c  = bus.req_y1;
        end
    end

    // The shared bitwise unit: 0 = AND, 1 = OR
    assign result_c = op_sel_c ? (x_sel_c | y_sel_c) : (x_sel_c & y_sel_c);

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        done_cnt0_d  = done_cnt0_q;
        done_cnt1_d  = done_cnt1_q;

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    rsp_data_d   = result_c;
                    last_grant_d = grant_c;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_hs_c) begin
                    if (last_grant_q) begin
                        done_cnt1_d = done_cnt1_q + CNT_W'(1);
                    end else begin
                        done_cnt0_d = done_cnt0_q + CNT_W'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rsp_valid_d = '0;
        if (state_d == RESP) begin
            rsp_valid_d = last_grant_d ? 2'b10 : 2'b01;
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset clears any in-flight result
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            rsp_data_q   <= '0;
            rsp_valid_q  <= '0;
            busy_q       <= 1'b0;
            done_cnt0_q  <= '0;
            done_cnt1_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
            done_cnt0_q  <= done_cnt0_d;
            done_cnt1_q  <= done_cnt1_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = busy_q;
    assign last_grant    = last_grant_q;
    assign done_cnt0     = done_cnt0_q;
    assign done_cnt1     = done_cnt1_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_logic_unit_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 4;
    localparam int          CMOD  = 1 << CNT_W;

    logic             clock;
    logic             reset_n;
    logic             busy;
    logic             last_grant;
    logic [CNT_W-1:0] done_cnt0;
    logic [CNT_W-1:0] done_cnt1;

    logic_unit_arbiter_if #(.WIDTH(WIDTH)) bus_if ();

    logic_unit_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus_if),
        .busy       (busy),
        .last_grant (last_grant),
        .done_cnt0  (done_cnt0),
        .done_cnt1  (done_cnt1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one job slot, owner, last winner, result, counts
    bit          m_busy;
    bit          m_last;
    logic [31:0] m_data;
    int          m_cnt [2];

    function automatic bit pick(input logic [1:0] v, input bit last);
        if (v == 2'b11) return !last;
        return (v == 2'b10);
    endfunction

    function automatic logic [31:0] calc(input bit op, input logic [31:0] x, input logic [31:0] y);
        return op ? (x | y) : (x & y);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0;
            m_last = 1'b1;
            m_data = '0;
            m_cnt[0] = 0;
            m_cnt[1] = 0;
        end else if (!m_busy) begin
            if (bus_if.req_valid != 2'b00) begin
                bit g;
                g = pick(bus_if.req_valid, m_last);
                m_data = g ? calc(bus_if.req_op1, bus_if.req_x1, bus_if.req_y1)
                           : calc(bus_if.req_op0, bus_if.req_x0, bus_if.req_y0);
                m_last = g;
                m_busy = 1'b1;
            end
        end else if (bus_if.rsp_ready[m_last]) begin
            m_cnt[m_last] = (m_cnt[m_last] + 1) % CMOD;
            m_busy = 1'b0;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model
    always @(negedge clock) begin
        if (cmp_en) begin
            logic [1:0] exp_rdy;
            logic [1:0] exp_vld;
            exp_rdy = 2'b00;
            if (!m_busy && bus_if.req_valid != 2'b00)
                exp_rdy = pick(bus_if.req_valid, m_last) ? 2'b10 : 2'b01;
            exp_vld = m_busy ? (m_last ? 2'b10 : 2'b01) : 2'b00;
            check("m_req_ready",  32'(bus_if.req_ready), 32'(exp_rdy));
            check("m_rsp_valid",  32'(bus_if.rsp_valid), 32'(exp_vld));
            check("m_rsp_data",   bus_if.rsp_data, m_data);
            check("m_busy",       32'(busy), 32'(m_busy));
            check("m_last_grant", 32'(last_grant), 32'(m_last));
            check("m_done_cnt0",  32'(done_cnt0), 32'(m_cnt[0]));
            check("m_done_cnt1",  32'(done_cnt1), 32'(m_cnt[1]));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    logic [31:0] saved;
    logic [1:0]  acc;
    logic [1:0]  v;

    initial begin
        reset_n = 1'b1;
        bus_if.req_valid = '0;
        bus_if.rsp_ready = '0;
        bus_if.req_op0 = 1'b0; bus_if.req_x0 = '0; bus_if.req_y0 = '0;
        bus_if.req_op1 = 1'b0; bus_if.req_x1 = '0; bus_if.req_y1 = '0;
        #1 reset_n = 1'b0;
        #1 cmp_en = 1'b1;
        step(); step();
        reset_n = 1'b1;

        // Reset values
        at_neg();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_last_grant", 32'(last_grant), 32'd1);
        check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("rst_rsp_data", bus_if.rsp_data, 32'd0);

        // Single AND request from requester 0
        step();
        bus_if.req_valid = 2'b01;
        bus_if.req_op0 = 1'b0; bus_if.req_x0 = 32'hF0F0_1234; bus_if.req_y0 = 32'h0FF0_FFFF;
        at_neg();
        check("and_req_ready", 32'(bus_if.req_ready), 32'h1);
        step();
        bus_if.req_valid = 2'b00;
        bus_if.rsp_ready = 2'b01;
        at_neg();
        check("and_rsp_valid", 32'(bus_if.rsp_valid), 32'h1);
        check("and_rsp_data", bus_if.rsp_data, 32'h00F0_1234);
        step();
        bus_if.rsp_ready = 2'b00;
        at_neg();
        check("and_done_cnt0", 32'(done_cnt0), 32'd1);
        check("and_idle", 32'(busy), 32'd0);

        // OR request from requester 1
        step();
        bus_if.req_valid = 2'b10;
        bus_if.req_op1 = 1'b1; bus_if.req_x1 = 32'h8000_0001; bus_if.req_y1 = 32'h0000_0100;
        at_neg();
        check("or_req_ready", 32'(bus_if.req_ready), 32'h2);
        step();
        bus_if.req_valid = 2'b00;
        bus_if.rsp_ready = 2'b10;
        at_neg();
        check("or_rsp_valid", 32'(bus_if.rsp_valid), 32'h2);
        check("or_rsp_data", bus_if.rsp_data, 32'h8000_0101);
        step();
        bus_if.rsp_ready = 2'b00;
        at_neg();
        check("or_done_cnt1", 32'(done_cnt1), 32'd1);
        check("or_last_grant", 32'(last_grant), 32'd1);

        // Contention: both always valid, zero-wait responses -> alternate 0,1,...
        step();
        bus_if.req_valid = 2'b11;
        bus_if.rsp_ready = 2'b11;
        for (int i = 0; i < 16; i++) begin
            at_neg();
            if (i % 2 == 0)
                check("cont_grant", 32'(bus_if.req_ready), (i % 4 == 0) ? 32'h1 : 32'h2);
            else
                check("cont_rsp_valid", 32'(bus_if.rsp_valid), (i % 4 == 1) ? 32'h1 : 32'h2);
            step();
        end
        bus_if.req_valid = 2'b00;
        bus_if.rsp_ready = 2'b00;
        at_neg();
        check("cont_cnt0", 32'(done_cnt0), 32'd5);
        check("cont_cnt1", 32'(done_cnt1), 32'd5);

        // Response stall holds everything and blocks the other requester
        step();
        bus_if.req_valid = 2'b01;
        bus_if.req_op0 = 1'b1; bus_if.req_x0 = 32'h1234_0000; bus_if.req_y0 = 32'h0000_5678;
        at_neg();
        check("stall_accept", 32'(bus_if.req_ready), 32'h1);
        step();
        bus_if.req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            check("stall_req_ready", 32'(bus_if.req_ready), 32'h0);
            check("stall_busy", 32'(busy), 32'd1);
            check("stall_rsp_valid", 32'(bus_if.rsp_valid), 32'h1);
            check("stall_rsp_data", bus_if.rsp_data, 32'h1234_5678);
            step();
        end
        bus_if.rsp_ready = 2'b01;
        at_neg();
        check("stall_hs_no_accept", 32'(bus_if.req_ready), 32'h0);
        step();
        bus_if.rsp_ready = 2'b00;
        at_neg();
        check("stall_other_accept", 32'(bus_if.req_ready), 32'h2);
        step();
        bus_if.req_valid = 2'b00;
        bus_if.rsp_ready = 2'b10;
        at_neg();
        step();
        bus_if.rsp_ready = 2'b00;

        // Async reset in RESP clears outputs without a clock edge
        bus_if.req_valid = 2'b01;
        at_neg();
        step();
        bus_if.req_valid = 2'b00;
        #2 reset_n = 1'b0;
        #1;
        check("arst_rsp_valid", 32'(bus_if.rsp_valid), 32'h0);
        check("arst_rsp_data", bus_if.rsp_data, 32'h0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cnt0", 32'(done_cnt0), 32'd0);
        check("arst_cnt1", 32'(done_cnt1), 32'd0);
        check("arst_last_grant", 32'(last_grant), 32'd1);
        step();
        reset_n = 1'b1;
        bus_if.req_valid = 2'b11;
        at_neg();
        check("arst_first_tie", 32'(bus_if.req_ready), 32'h1);
        step();
        bus_if.req_valid = 2'b10;
        bus_if.rsp_ready = 2'b11;
        at_neg();
        step();
        at_neg();
        step();
        bus_if.req_valid = 2'b00;
        at_neg();
        step();
        bus_if.rsp_ready = 2'b00;

        // Counter wrap: 17 ops on requester 0 from a fresh reset
        #2 reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        bus_if.req_valid = 2'b01;
        bus_if.rsp_ready = 2'b01;
        for (int i = 0; i < 34; i++) step();
        bus_if.req_valid = 2'b00;
        bus_if.rsp_ready = 2'b00;
        at_neg();
        check("wrap_cnt0", 32'(done_cnt0), 32'd1);

        // Random traffic obeying the hold-until-accepted rule
        v = 2'b00;
        for (int c = 0; c < 600; c++) begin
            at_neg();
            acc = bus_if.req_valid & bus_if.req_ready;
            step();
            for (int i = 0; i < 2; i++) begin
                if (!v[i] || acc[i]) begin
                    v[i] = ($urandom_range(0, 2) != 0);
                    if (i == 0) begin
                        bus_if.req_op0 = 1'($urandom);
                        bus_if.req_x0 = $urandom;
                        bus_if.req_y0 = $urandom;
                    end else begin
                        bus_if.req_op1 = 1'($urandom);
                        bus_if.req_x1 = $urandom;
                        bus_if.req_y1 = $urandom;
                    end
                end
            end
            bus_if.req_valid = v;
            bus_if.rsp_ready = 2'($urandom);
        end
        bus_if.req_valid = 2'b00;
        bus_if.rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) step();
        at_neg();
        saved = 32'(m_cnt[0] + m_cnt[1]);
        check("final_idle", 32'(busy), 32'd0);
        check("final_total_cnt", 32'(done_cnt0) + 32'(done_cnt1), saved);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
